// File: rtl/lemming_dig_arbiter.sv
// N independent lemming walk/fall/dig FSMs sharing one round-robin arbitrated shovel.
// Optional fall-death supervision (fall counter + SPLAT) is enabled by defining LEMMING_SPLAT_EN.
module lemming_dig_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned FALL_LIMIT = 20
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic [N-1:0]           bump_left,
    input  logic [N-1:0]           bump_right,
    input  logic [N-1:0]           ground,
    input  logic [N-1:0]           dig_req,
    output logic [N-1:0]           walk_left,
    output logic [N-1:0]           walk_right,
    output logic [N-1:0]           aaah,
    output logic [N-1:0]           digging,
    output logic [N-1:0]           splat,
    output logic                   shovel_busy,
    output logic [$clog2(N)-1:0]   shovel_owner
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned CW = 8;

    // Reject parameter values the counters and pointer are not sized for
    if (N < 2 || N > 8 || FALL_LIMIT < 1 || FALL_LIMIT > 254) begin : g_param_check
        $error("lemming_dig_arbiter: N or FALL_LIMIT out of range");
    end

    typedef enum logic [2:0] {
        S_WL    = 3'd0,
        S_WR    = 3'd1,
        S_FALLL = 3'd2,
        S_FALLR = 3'd3,
        S_DIGL  = 3'd4,
        S_DIGR  = 3'd5
`ifdef LEMMING_SPLAT_EN
        ,S_SPLAT = 3'd6
`endif
    } state_t;

    state_t          state_q [N];
    state_t          state_d [N];
    logic [OW-1:0]   rr_ptr_q;
    logic [OW-1:0]   rr_ptr_d;
    logic [N-1:0]    eligible;
    logic [N-1:0]    grant_vec;
    logic            grant_valid;
    logic [OW-1:0]   grant_idx;

    logic [N-1:0]    wl_d;
    logic [N-1:0]    wr_d;
    logic [N-1:0]    aa_d;
    logic [N-1:0]    dig_d;
    logic [OW-1:0]   owner_d;

`ifdef LEMMING_SPLAT_EN
    logic [CW-1:0]   fall_q [N];
    logic [CW-1:0]   fall_d [N];
    logic [N-1:0]    sp_d;
`endif

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return OW'(s);
    endfunction

    // Round-robin search from rr_ptr_q; the shovel is only offered while idle
    always_comb begin
        eligible    = '0;
        grant_vec   = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = ((state_q[i] == S_WL) || (state_q[i] == S_WR)) &&
                          ground[i] && dig_req[i] && !shovel_busy;
        end
        for (int off = 0; off < N; off++) begin
            if (!grant_valid && eligible[wrap_add(rr_ptr_q, 32'(off))]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr_q, 32'(off));
            end
        end
        for (int i = 0; i < N; i++) begin
            grant_vec[i] = grant_valid && (grant_idx == OW'(i));
        end
        rr_ptr_d = grant_valid ? wrap_add(grant_idx, 32'd1) : rr_ptr_q;
    end

    // Per-lemming next state; fall has priority over grant, grant over bump
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
`ifdef LEMMING_SPLAT_EN
            fall_d[i]  = '0;
`endif
            case (state_q[i])
                S_WL: begin
                    if (!ground[i])        state_d[i] = S_FALLL;
                    else if (grant_vec[i]) state_d[i] = S_DIGL;
                    else if (bump_left[i]) state_d[i] = S_WR;
                end
                S_WR: begin
                    if (!ground[i])         state_d[i] = S_FALLR;
                    else if (grant_vec[i])  state_d[i] = S_DIGR;
                    else if (bump_right[i]) state_d[i] = S_WL;
                end
                S_FALLL, S_FALLR: begin
                    if (ground[i]) begin
`ifdef LEMMING_SPLAT_EN
                        if (fall_q[i] >= CW'(FALL_LIMIT))  state_d[i] = S_SPLAT;
                        else if (state_q[i] == S_FALLL)    state_d[i] = S_WL;
                        else                               state_d[i] = S_WR;
`else
                        state_d[i] = (state_q[i] == S_FALLL) ? S_WL : S_WR;
`endif
                    end
`ifdef LEMMING_SPLAT_EN
                    else begin
                        fall_d[i] = (fall_q[i] == '1) ? fall_q[i] : fall_q[i] + CW'(1);
                    end
`endif
                end
                S_DIGL: begin
                    if (!ground[i]) state_d[i] = S_FALLL;
                end
                S_DIGR: begin
                    if (!ground[i]) state_d[i] = S_FALLR;
                end
`ifdef LEMMING_SPLAT_EN
                S_SPLAT: state_d[i] = S_SPLAT;
`endif
                default: state_d[i] = S_WL;
            endcase
        end
    end

    // Output decode from next state so the registered outputs track the state register
    always_comb begin
        wl_d    = '0;
        wr_d    = '0;
        aa_d    = '0;
        dig_d   = '0;
        owner_d = '0;
`ifdef LEMMING_SPLAT_EN
        sp_d    = '0;
`endif
        for (int i = 0; i < N; i++) begin
            wl_d[i]  = (state_d[i] == S_WL);
            wr_d[i]  = (state_d[i] == S_WR);
            aa_d[i]  = (state_d[i] == S_FALLL) || (state_d[i] == S_FALLR);
            dig_d[i] = (state_d[i] == S_DIGL) || (state_d[i] == S_DIGR);
`ifdef LEMMING_SPLAT_EN
            sp_d[i]  = (state_d[i] == S_SPLAT);
`endif
            if (dig_d[i]) owner_d = OW'(i);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= S_WL;
            end
            rr_ptr_q     <= '0;
            walk_left    <= '1;
            walk_right   <= '0;
            aaah         <= '0;
            digging      <= '0;
            shovel_busy  <= 1'b0;
            shovel_owner <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
            rr_ptr_q     <= rr_ptr_d;
            walk_left    <= wl_d;
            walk_right   <= wr_d;
            aaah         <= aa_d;
            digging      <= dig_d;
            shovel_busy  <= |dig_d;
            shovel_owner <= owner_d;
        end
    end

`ifdef LEMMING_SPLAT_EN
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N; i++) begin
                fall_q[i] <= '0;
            end
            splat <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                fall_q[i] <= fall_d[i];
            end
            splat <= sp_d;
        end
    end
`else
    assign splat = '0;
`endif

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Scoreboard bench for lemming_dig_arbiter (N=4, FALL_LIMIT=20); driver queues expectations, monitor checks.
module tb_lemming_dig_arbiter;

    logic       clk;
    logic       areset_n;
    logic [3:0] bl, br, gnd, req;
    logic [3:0] walk_left, walk_right, aaah, digging, splat;
    logic       shovel_busy;
    logic [1:0] shovel_owner;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       nm;
        logic [22:0] v;
    } exp_t;

    exp_t exp_q [$];

    lemming_dig_arbiter #(.N(4), .FALL_LIMIT(20)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .bump_left    (bl),
        .bump_right   (br),
        .ground       (gnd),
        .dig_req      (req),
        .walk_left    (walk_left),
        .walk_right   (walk_right),
        .aaah         (aaah),
        .digging      (digging),
        .splat        (splat),
        .shovel_busy  (shovel_busy),
        .shovel_owner (shovel_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] e(input logic [3:0] wl, input logic [3:0] wr, input logic [3:0] aa,
                                      input logic [3:0] dg, input logic [3:0] sp, input logic busy,
                                      input logic [1:0] own);
        return {wl, wr, aa, dg, sp, busy, own};
    endfunction

    function automatic logic [22:0] act_vec();
        return {walk_left, walk_right, aaah, digging, splat, shovel_busy, shovel_owner};
    endfunction

    task automatic check(input string nm, input logic [22:0] act, input logic [22:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got wl=%b wr=%b aa=%b dg=%b sp=%b busy=%b own=%0d, expected wl=%b wr=%b aa=%b dg=%b sp=%b busy=%b own=%0d",
                     nm, act[22:19], act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1:0],
                     exp[22:19], exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    // One cycle of stimulus; the expectation describes outputs after the next rising edge
    task automatic step(input string nm, input logic [3:0] bl_i, input logic [3:0] br_i,
                        input logic [3:0] gnd_i, input logic [3:0] req_i, input logic [22:0] ev);
        exp_t x;
        @(posedge clk);
        #2;
        bl  = bl_i;
        br  = br_i;
        gnd = gnd_i;
        req = req_i;
        x.nm = nm;
        x.v  = ev;
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #3;
        bl  = '0;
        br  = '0;
        gnd = '1;
        req = '0;
        areset_n = 1'b0;
        #1;
        check(nm, act_vec(), e(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    // Monitor: pops one expectation per cycle, also checks single-owner invariant
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check(x.nm, act_vec(), x.v);
                n_tests++;
                if (!$onehot0(digging)) begin
                    n_fail++;
                    $display("FAIL onehot_dig(%s): got digging=%b, expected at most one bit", x.nm, digging);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        areset_n = 1'b0;
        bl  = '0;
        br  = '0;
        gnd = '1;
        req = '0;
        #12;
        check("reset_init", act_vec(), e(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        @(negedge clk);
        areset_n = 1'b1;

        // Walking and bump handling
        step("bump_l2",      4'b0100, 4'b0000, 4'b1111, 4'b0000, e(4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("wl_ign_br",    4'b0000, 4'b0001, 4'b1111, 4'b0000, e(4'b1011, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("bump_r2",      4'b0000, 4'b0100, 4'b1111, 4'b0000, e(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));

        // Round robin with a bumped loser
        do_reset("reset_rr");
        step("rr_g0",        4'b0010, 4'b0000, 4'b1111, 4'b1111, e(4'b1100, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));
        step("rr_hold0",     4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b1100, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));
        step("rr_drop0",     4'b0000, 4'b0000, 4'b1110, 4'b1111, e(4'b1100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("rr_g1",        4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b1101, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1));
        step("rr_drop1",     4'b0000, 4'b0000, 4'b1101, 4'b1111, e(4'b1101, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("rr_g2",        4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b1001, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2));
        step("rr_drop2",     4'b0000, 4'b0000, 4'b1011, 4'b1111, e(4'b1001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("rr_g3",        4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b0101, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3));
        step("rr_drop3",     4'b0000, 4'b0000, 4'b0111, 4'b1111, e(4'b0101, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("rr_wrap0",     4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b1100, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));
        step("rr_drop0b",    4'b0000, 4'b0000, 4'b1110, 4'b1111, e(4'b1100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0));

        // Fall beats a same-cycle request; lemming 3 wins instead
        step("fall_vs_grant",4'b0000, 4'b0000, 4'b1101, 4'b1010, e(4'b0101, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 1'b1, 2'd3));
        step("dig_ign_bump", 4'b1000, 4'b1000, 4'b1111, 4'b0000, e(4'b0101, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3));
        step("dig_to_fall",  4'b0000, 4'b0000, 4'b0111, 4'b0000, e(4'b0101, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("land3",        4'b0000, 4'b0000, 4'b1111, 4'b0000, e(4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));

        // Fall length boundary
        do_reset("reset_fall");
        for (int k = 0; k < 20; k++)
            step("fall20",   4'b0000, 4'b0000, 4'b1110, 4'b0000, e(4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("land20",       4'b0000, 4'b0000, 4'b1111, 4'b0000, e(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        for (int k = 0; k < 21; k++)
            step("fall21",   4'b0000, 4'b0000, 4'b1110, 4'b0000, e(4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0));
`ifdef LEMMING_SPLAT_EN
        step("land21_splat", 4'b0000, 4'b0000, 4'b1111, 4'b0000, e(4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0));
        step("splat_br_req", 4'b0000, 4'b0001, 4'b1111, 4'b0001, e(4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0));
        step("splat_bl",     4'b0001, 4'b0000, 4'b1111, 4'b0000, e(4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0));
`else
        step("land21_walk",  4'b0000, 4'b0000, 4'b1111, 4'b0000, e(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0));
        step("walk_br_req",  4'b0000, 4'b0001, 4'b1111, 4'b0001, e(4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));
        step("dig_bl",       4'b0001, 4'b0000, 4'b1111, 4'b0000, e(4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));
`endif

        // Reset during a dig frees the shovel and rewinds the pointer
        do_reset("reset_pre_dig");
        step("g2",           4'b0000, 4'b0000, 4'b1111, 4'b0100, e(4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2));
        step("hold2",        4'b0000, 4'b0000, 4'b1111, 4'b0100, e(4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2));
        do_reset("reset_mid_dig");
        step("post_rst_g0",  4'b0000, 4'b0000, 4'b1111, 4'b1111, e(4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0));

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lemming_dig_arbiter.md
# lemming_dig_arbiter

Multi-lemming controller: runs N independent walk/fall/dig state machines and arbitrates a single shared shovel among them. Grants go round-robin, one dig at a time. It sits above the per-lemming walker logic and sequences which lemming may dig; the fall/splat supervision lives in the same block.

## Interface
- N, 4, number of lemmings (2..8)
- FALL_LIMIT, 20, maximum survivable fall length in cycles (1..254)
- clk  in  1  clock, all state updates on rising edge
- areset_n  in  1  asynchronous active-low reset
- bump_left  in  N  per-lemming left bump
- bump_right  in  N  per-lemming right bump
- ground  in  N  per-lemming ground present
- dig_req  in  N  per-lemming request for the shovel
- walk_left  out  N  lemming in WL
- walk_right  out  N  lemming in WR
- aaah  out  N  lemming in FALLL or FALLR
- digging  out  N  lemming in DIGL or DIGR
- splat  out  N  lemming in SPLAT
- shovel_busy  out  1  some lemming is digging
- shovel_owner  out  clog2(N)  index of digging lemming; 0 when not busy

## Operation
- Per-lemming states: WL, WR, FALLL, FALLR, DIGL, DIGR, SPLAT. Outputs are decoded from registered state (Moore).
- Reset (async, areset_n=0): every lemming WL, fall counters 0, RR pointer 0. Outputs: walk_left all 1, all others 0, shovel_owner 0.
- WL/WR transition priority:
  - ground=0 -> FALLL/FALLR (same direction).
  - Otherwise, granted -> DIGL/DIGR.
  - Otherwise, bump on the facing side -> reverse direction. WL reverses on bump_left, WR on bump_right; the other bump is ignored.
  - Otherwise, stay.
- Grant rules:
  - A lemming is eligible when it is in WL/WR, has ground=1 and dig_req=1, and shovel_busy=0.
  - At most one grant per cycle.
  - Search starts at the RR pointer and wraps upward through index N-1 back to 0. The first eligible lemming wins.
  - After a grant to lemming i, pointer = (i+1) mod N. With no grant, the pointer holds.
- DIGL/DIGR: ground=1 -> stay; bumps and dig_req are ignored. ground=0 -> FALLL/FALLR, which releases the shovel.
- FALLL/FALLR:
  - fall_cnt counts completed cycles in the FALL state (8-bit, saturates at 255) and is cleared in every non-FALL state.
  - ground=1 with fall_cnt >= FALL_LIMIT -> SPLAT.
  - ground=1 otherwise -> WL/WR (direction preserved).
  - ground=0 -> stay.
- SPLAT: terminal until reset. All its outputs are 0, except splat=1. It is never eligible for a grant.
- shovel_busy = OR of digging. shovel_owner = encoded index of the digging lemming (at most one, by construction).

## Timing
- Every state change lands one cycle after the input that causes it.
- A grant decided in cycle t shows as digging=1 and shovel_busy=1 in cycle t+1.
- The owner's ground drops in cycle t; it is in FALL at t+1 with shovel_busy=0. The earliest new grant is decided at t+1, so the next digging=1 appears at t+2.
- Simultaneous requests: only the RR winner digs. Losers keep walking (a bump is still applied) and must hold dig_req to retry.
- A request at the same edge as ground=0 loses to the fall.
- Reset mid-dig or mid-fall returns the lemming immediately to WL and frees the shovel.
- Falls: ground low for k consecutive cycles gives k cycles of aaah=1. FALL_LIMIT=20: k=20 survives, k=21 splats.

## Configuration
- LEMMING_SPLAT_EN defined: splat behaviour as above; fall_cnt and SPLAT are present.
- LEMMING_SPLAT_EN undefined:
  - fall_cnt and SPLAT are removed.
  - FALL always returns to walking on ground=1.
  - The splat output is tied to 0.

## Test plan
- Reset and walk (N=4): release areset_n with ground=all 1 -> walk_left=4'b1111. Pulse bump_left[2] -> walk_right[2]=1 the next cycle; the other lemmings are unchanged.
- RR arbitration: all 4 lemmings hold dig_req=1 and ground=1 from reset.
  - Lemming 0 digs first. Dropping ground[0] for one cycle releases the shovel.
  - Lemming 1 is digging 2 cycles after the drop, then 2, 3, 0 in turn.
  - shovel_owner tracks each owner, and at most one digging bit is ever set.
- Grant vs fall: lemming 1 requests in the same cycle ground[1]=0 -> aaah[1]=1, no grant. Lemming 3 requesting in that cycle is granted.
- Splat boundary (FALL_LIMIT=20, macro defined):
  - ground[0] low for 20 cycles -> walk_left[0] after landing.
  - ground[0] low for 21 cycles -> splat[0]=1, stuck there even if bump_right[0]/dig_req[0] are pulsed, until areset_n.
  - With the macro undefined, the 21-cycle fall returns to walk_left[0]=1.
- Reset mid-dig: assert areset_n=0 while lemming 2 is digging -> all outputs at reset values asynchronously. After release, lemming 0 wins the first grant (pointer=0).
